wb_sequencer: RTL and testbench
===============================

Name: wb_sequencer

Overview:
- Controls register-file writeback when data memory has variable latency.
- Sits between decode/control and the writeback select mux:
  - Drives the mux select wb_sel and the regfile write enable.
  - Stalls the processor while a load or store is outstanding on the memory request/grant/rvalid handshake.
  - Holds the loaded data in a register and writes it back in a single cycle.
- Non-memory instructions pass straight through with zero latency.

Parameters:
- TIMEOUT_CYCLES, 255: maximum cycles spent in REQ plus WAIT before the access is aborted.
- CNT_W, $clog2(TIMEOUT_CYCLES+1): width of the timeout counter (derived; do not override).

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  asynchronous, active-high reset
- instr_valid  in  1  current instruction valid
- wb_sel_in  in  2  decoded select: 00 ALU, 01 load data, 10 PC+4
- reg_wr_in  in  1  decoded regfile write enable
- rd_in  in  5  destination register
- is_load  in  1  instruction is a load
- is_store  in  1  instruction is a store
- mem_gnt  in  1  memory accepted the request
- mem_rvalid  in  1  load data valid
- mem_rdata  in  32  load data from memory
- mem_req  out  1  memory request; held until granted
- stall  out  1  freeze PC and pipeline inputs
- wb_sel  out  2  to the writeback mux
- reg_wr  out  1  regfile write enable
- rd_out  out  5  regfile write address
- rdata_q  out  32  captured load data; drives mux input 01
- bus_err  out  1  one-cycle pulse when an access times out

Behaviour:
- Reset values: FSM = IDLE, counter = 0, rdata_q = 0, latched rd = 0, load flag = 0.
- All outputs are 0 while rst is high.
- States: IDLE, REQ, WAIT, WB, ERR. The encoding is in the package.

IDLE:
- If instr_valid and neither is_load nor is_store:
  - wb_sel = wb_sel_in
  - reg_wr = reg_wr_in and (rd_in != 0)
  - rd_out = rd_in
  - stall = 0
  - These outputs are combinational, with 0-cycle latency.
- If instr_valid and (is_load or is_store):
  - stall = 1, reg_wr = 0, mem_req = 1 in the same cycle.
  - Latch rd_in and is_load.
  - If mem_gnt is high in this cycle: go to WAIT (load) or WB (store). Otherwise go to REQ.
- If is_load and is_store are both high, is_load wins.

REQ:
- mem_req = 1, stall = 1.
- On mem_gnt: go to WAIT (load) or WB (store).

WAIT (loads only):
- stall = 1, mem_req = 0.
- On mem_rvalid: capture mem_rdata into rdata_q, go to WB.
- mem_rvalid in the same cycle as mem_gnt is legal:
  - From IDLE or REQ, capture the data and go directly to WB.

WB:
- Lasts exactly one cycle.
- stall = 0, so the pipeline advances at the end of the cycle. Go to IDLE.
- Load:
  - wb_sel = 01
  - reg_wr = (latched rd != 0)
  - rd_out = latched rd
- Store:
  - reg_wr = 0, wb_sel = 00.

ERR:
- bus_err = 1, stall = 0, reg_wr = 0. Lasts one cycle, then IDLE.
- No writeback occurs, and rdata_q is unchanged.

Timeout:
- The counter clears on entry from IDLE and increments every cycle spent in REQ or WAIT.
- When counter == TIMEOUT_CYCLES-1 and the state's exit event is absent, go to ERR.
- A grant or rvalid arriving in the same cycle as the timeout wins over the timeout.

Other rules:
- mem_gnt or mem_rvalid arriving in IDLE, WB or ERR without an outstanding request is ignored.
- Reset mid-access returns to IDLE immediately.
  - A late mem_rvalid after reset is ignored.
- wb_sel defaults to 00 in every state not listed above.
- An instruction with instr_valid = 0 in IDLE produces all-zero outputs.

Decomposition:
- Package wb_pkg holds:
  - typedef enum logic [2:0] wb_state_e {IDLE, REQ, WAIT, WB, ERR}
  - typedef enum logic [1:0] wb_sel_e {WB_ALU = 2'b00, WB_MEM = 2'b01, WB_PC4 = 2'b10}
- Use wb_sel_e in both this block and the writeback mux.
- Sub-module wb_timeout_counter: clear, enable and expired signals, parameterised by TIMEOUT_CYCLES.

Test Plan:
- ALU instruction: wb_sel_in = 00, reg_wr_in = 1, rd_in = 5 -> same cycle wb_sel = 00, reg_wr = 1, rd_out = 5, stall = 0. With rd_in = 0, reg_wr = 0.
- Load, grant at +2 cycles, rvalid at +4 with mem_rdata = 32'hDEADBEEF, rd = 7:
  - stall held for 5 cycles.
  - Then one WB cycle: wb_sel = 01, reg_wr = 1, rd_out = 7, rdata_q = DEADBEEF, stall = 0.
- Store, gnt in the issue cycle -> stall high for 1 cycle, then WB with reg_wr = 0. No further mem_req.
- Load with gnt and rvalid both in the issue cycle -> WB on the next cycle. Total stall is 1 cycle.
- TIMEOUT_CYCLES = 4, load granted, rvalid never arrives -> bus_err pulses for exactly one cycle after 4 WAIT cycles, reg_wr stays 0, FSM returns to IDLE.
- Assert rst during WAIT, release, then drive a stray mem_rvalid -> all outputs 0, no writeback, rdata_q = 0.

Source files
------------

// File: rtl/wb_pkg.sv
// Shared types for the writeback sequencer and the writeback select mux.
package wb_pkg;

    typedef enum logic [2:0] {IDLE, REQ, WAIT, WB, ERR} wb_state_e;

    typedef enum logic [1:0] {
        WB_ALU = 2'b00,
        WB_MEM = 2'b01,
        WB_PC4 = 2'b10
    } wb_sel_e;

endpackage

// File: rtl/wb_timeout_counter.sv
// Cycle counter bounding how long a memory access may stay outstanding.
module wb_timeout_counter #(
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES + 1);

    logic [CNT_W-1:0] count;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (enable) begin
            count <= count + 1'b1;
        end
    end

    // Asserted during the last permitted cycle; the FSM decides if an exit event overrides it.
    assign expired = (count == CNT_W'(TIMEOUT_CYCLES - 1));

endmodule

// File: rtl/wb_sequencer.sv
// Regfile writeback sequencer: stalls across variable-latency loads/stores and
// writes captured load data back in a single cycle.
module wb_sequencer
    import wb_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          instr_valid,
    input  logic [1:0]    wb_sel_in,
    input  logic          reg_wr_in,
    input  logic [4:0]    rd_in,
    input  logic          is_load,
    input  logic          is_store,
    input  logic          mem_gnt,
    input  logic          mem_rvalid,
    input  logic [31:0]   mem_rdata,
    output logic          mem_req,
    output logic          stall,
    output wb_sel_e       wb_sel,
    output logic          reg_wr,
    output logic [4:0]    rd_out,
    output logic [31:0]   rdata_q,
    output logic          bus_err
);

    wb_state_e  state;
    logic [4:0] rd_q;
    logic       load_q;
    logic       expired;
    logic       mem_access;

    assign mem_access = instr_valid && (is_load || is_store);

    wb_timeout_counter #(
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) u_timeout (
        .clk     (clk),
        .rst     (rst),
        .clear   (state == IDLE),
        .enable  ((state == REQ) || (state == WAIT)),
        .expired (expired)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= IDLE;
            rd_q    <= '0;
            load_q  <= 1'b0;
            rdata_q <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (mem_access) begin
                        rd_q   <= rd_in;
                        load_q <= is_load;
                        if (!mem_gnt) begin
                            state <= REQ;
                        end else if (!is_load) begin
                            state <= WB;
                        end else if (mem_rvalid) begin
                            rdata_q <= mem_rdata;
                            state   <= WB;
                        end else begin
                            state <= WAIT;
                        end
                    end
                end
                REQ: begin
                    // A grant in the final cycle beats the timeout.
                    if (mem_gnt) begin
                        if (!load_q) begin
                            state <= WB;
                        end else if (mem_rvalid) begin
                            rdata_q <= mem_rdata;
                            state   <= WB;
                        end else begin
                            state <= WAIT;
                        end
                    end else if (expired) begin
                        state <= ERR;
                    end
                end
                WAIT: begin
                    if (mem_rvalid) begin
                        rdata_q <= mem_rdata;
                        state   <= WB;
                    end else if (expired) begin
                        state <= ERR;
                    end
                end
                WB:      state <= IDLE;
                ERR:     state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    always_comb begin
        mem_req = 1'b0;
        stall   = 1'b0;
        wb_sel  = WB_ALU;
        reg_wr  = 1'b0;
        rd_out  = '0;
        bus_err = 1'b0;
        // IDLE outputs follow the inputs directly, so they must be gated during reset.
        if (!rst) begin
            case (state)
                IDLE: begin
                    if (mem_access) begin
                        mem_req = 1'b1;
                        stall   = 1'b1;
                    end else if (instr_valid) begin
                        wb_sel = wb_sel_e'(wb_sel_in);
                        reg_wr = reg_wr_in && (rd_in != 5'd0);
                        rd_out = rd_in;
                    end
                end
                REQ: begin
                    mem_req = 1'b1;
                    stall   = 1'b1;
                end
                WAIT: stall = 1'b1;
                WB: begin
                    if (load_q) begin
                        wb_sel = WB_MEM;
                        reg_wr = (rd_q != 5'd0);
                        rd_out = rd_q;
                    end
                end
                ERR:     bus_err = 1'b1;
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_wb_sequencer.sv
// Directed bench for wb_sequencer with a short timeout so abort paths are reachable.
module tb_wb_sequencer;

    logic        clk;
    logic        rst;
    logic        instr_valid;
    logic [1:0]  wb_sel_in;
    logic        reg_wr_in;
    logic [4:0]  rd_in;
    logic        is_load;
    logic        is_store;
    logic        mem_gnt;
    logic        mem_rvalid;
    logic [31:0] mem_rdata;
    logic        mem_req;
    logic        stall;
    logic [1:0]  wb_sel;
    logic        reg_wr;
    logic [4:0]  rd_out;
    logic [31:0] rdata_q;
    logic        bus_err;

    int checks = 0;
    int errors = 0;
    int scnt;
    int rlate;

    wb_sequencer #(
        .TIMEOUT_CYCLES (4)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .instr_valid (instr_valid),
        .wb_sel_in   (wb_sel_in),
        .reg_wr_in   (reg_wr_in),
        .rd_in       (rd_in),
        .is_load     (is_load),
        .is_store    (is_store),
        .mem_gnt     (mem_gnt),
        .mem_rvalid  (mem_rvalid),
        .mem_rdata   (mem_rdata),
        .mem_req     (mem_req),
        .stall       (stall),
        .wb_sel      (wb_sel),
        .reg_wr      (reg_wr),
        .rd_out      (rd_out),
        .rdata_q     (rdata_q),
        .bus_err     (bus_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic drive_alu(input logic v, input logic [1:0] sel, input logic we,
                             input logic [4:0] rd);
        instr_valid = v;
        wb_sel_in   = sel;
        reg_wr_in   = we;
        rd_in       = rd;
        is_load     = 1'b0;
        is_store    = 1'b0;
        mem_gnt     = 1'b0;
        mem_rvalid  = 1'b0;
    endtask

    // Issues a load/store and holds it until stall drops; returns at the negedge of
    // the first non-stalled cycle (WB or ERR). gnt_at/rv_at are cycle offsets, -1 = never.
    task automatic mem_op(input string tag, input logic ld, input logic both,
                          input logic [4:0] rd, input logic [31:0] data,
                          input int gnt_at, input int rv_at,
                          output int stall_cnt, output int req_late);
        int  k;
        logic done;
        instr_valid = 1'b1;
        is_load     = ld;
        is_store    = !ld || both;
        rd_in       = rd;
        wb_sel_in   = ld ? 2'b01 : 2'b00;
        reg_wr_in   = ld;
        mem_rdata   = data;
        stall_cnt   = 0;
        req_late    = 0;
        done        = 1'b0;
        k           = 0;
        while (!done && k < 12) begin
            mem_gnt    = (k == gnt_at);
            mem_rvalid = (k == rv_at);
            @(negedge clk);
            if (mem_req && gnt_at >= 0 && k > gnt_at) req_late++;
            if (!stall) begin
                done = 1'b1;
            end else begin
                stall_cnt++;
                @(posedge clk);
                #1;
                k++;
            end
        end
        check({tag, "_done"}, {31'd0, done}, 32'd1);
    endtask

    // One cycle back in IDLE with no instruction: everything quiet.
    task automatic idle_cycle(input string tag);
        @(posedge clk);
        #1;
        drive_alu(1'b0, 2'b00, 1'b0, 5'd0);
        @(negedge clk);
        check({tag, "_stall"}, {31'd0, stall}, 32'd0);
        check({tag, "_reg_wr"}, {31'd0, reg_wr}, 32'd0);
        check({tag, "_bus_err"}, {31'd0, bus_err}, 32'd0);
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst       = 1'b1;
        mem_rdata = '0;
        drive_alu(1'b1, 2'b10, 1'b1, 5'd5);
        @(negedge clk);
        check("rst_reg_wr", {31'd0, reg_wr}, 32'd0);
        check("rst_rd_out", {27'd0, rd_out}, 32'd0);
        check("rst_wb_sel", {30'd0, wb_sel}, 32'd0);
        check("rst_rdata", rdata_q, 32'd0);
        check("rst_mem_req", {31'd0, mem_req}, 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;

        // Non-memory instructions are combinational pass-through.
        drive_alu(1'b1, 2'b00, 1'b1, 5'd5);
        @(negedge clk);
        check("alu_wb_sel", {30'd0, wb_sel}, 32'd0);
        check("alu_reg_wr", {31'd0, reg_wr}, 32'd1);
        check("alu_rd_out", {27'd0, rd_out}, 32'd5);
        check("alu_stall", {31'd0, stall}, 32'd0);
        drive_alu(1'b1, 2'b00, 1'b1, 5'd0);
        #1;
        check("alu_rd0_reg_wr", {31'd0, reg_wr}, 32'd0);
        drive_alu(1'b1, 2'b10, 1'b1, 5'd3);
        #1;
        check("pc4_wb_sel", {30'd0, wb_sel}, 32'd2);
        check("pc4_reg_wr", {31'd0, reg_wr}, 32'd1);
        drive_alu(1'b0, 2'b10, 1'b1, 5'd5);
        #1;
        check("inv_reg_wr", {31'd0, reg_wr}, 32'd0);
        check("inv_rd_out", {27'd0, rd_out}, 32'd0);
        check("inv_wb_sel", {30'd0, wb_sel}, 32'd0);
        @(posedge clk);
        #1;

        // Load: grant at +2, rvalid at +4 (rvalid coincides with the last allowed cycle).
        mem_op("ld1", 1'b1, 1'b0, 5'd7, 32'hDEADBEEF, 2, 4, scnt, rlate);
        check("ld1_stalls", scnt, 32'd5);
        check("ld1_wb_sel", {30'd0, wb_sel}, 32'd1);
        check("ld1_reg_wr", {31'd0, reg_wr}, 32'd1);
        check("ld1_rd_out", {27'd0, rd_out}, 32'd7);
        check("ld1_rdata", rdata_q, 32'hDEADBEEF);
        check("ld1_req_late", rlate, 32'd0);
        idle_cycle("ld1_post");

        // Store granted in the issue cycle.
        mem_op("st1", 1'b0, 1'b0, 5'd9, 32'h0, 0, -1, scnt, rlate);
        check("st1_stalls", scnt, 32'd1);
        check("st1_reg_wr", {31'd0, reg_wr}, 32'd0);
        check("st1_wb_sel", {30'd0, wb_sel}, 32'd0);
        check("st1_req_late", rlate, 32'd0);
        check("st1_rdata", rdata_q, 32'hDEADBEEF);
        idle_cycle("st1_post");

        // Load with grant and rvalid both in the issue cycle.
        mem_op("ld2", 1'b1, 1'b0, 5'd9, 32'h12345678, 0, 0, scnt, rlate);
        check("ld2_stalls", scnt, 32'd1);
        check("ld2_reg_wr", {31'd0, reg_wr}, 32'd1);
        check("ld2_rd_out", {27'd0, rd_out}, 32'd9);
        check("ld2_rdata", rdata_q, 32'h12345678);
        idle_cycle("ld2_post");

        // Load to x0: data captured, no regfile write.
        mem_op("ld3", 1'b1, 1'b0, 5'd0, 32'hA5A5A5A5, 0, 1, scnt, rlate);
        check("ld3_stalls", scnt, 32'd2);
        check("ld3_reg_wr", {31'd0, reg_wr}, 32'd0);
        check("ld3_wb_sel", {30'd0, wb_sel}, 32'd1);
        check("ld3_rdata", rdata_q, 32'hA5A5A5A5);
        idle_cycle("ld3_post");

        // Load never answered: 4 WAIT cycles then one ERR cycle.
        mem_op("to_wait", 1'b1, 1'b0, 5'd6, 32'hFFFF0000, 0, -1, scnt, rlate);
        check("to_wait_stalls", scnt, 32'd5);
        check("to_wait_bus_err", {31'd0, bus_err}, 32'd1);
        check("to_wait_reg_wr", {31'd0, reg_wr}, 32'd0);
        check("to_wait_rdata", rdata_q, 32'hA5A5A5A5);
        idle_cycle("to_wait_post");

        // Store never granted: times out from REQ.
        mem_op("to_req", 1'b0, 1'b0, 5'd6, 32'h0, -1, -1, scnt, rlate);
        check("to_req_stalls", scnt, 32'd5);
        check("to_req_bus_err", {31'd0, bus_err}, 32'd1);
        idle_cycle("to_req_post");

        // Grant in the final REQ cycle beats the timeout.
        mem_op("gnt_edge", 1'b0, 1'b0, 5'd6, 32'h0, 4, -1, scnt, rlate);
        check("gnt_edge_stalls", scnt, 32'd5);
        check("gnt_edge_bus_err", {31'd0, bus_err}, 32'd0);
        check("gnt_edge_reg_wr", {31'd0, reg_wr}, 32'd0);
        idle_cycle("gnt_edge_post");

        // is_load and is_store together behave as a load.
        mem_op("both", 1'b1, 1'b1, 5'd4, 32'h0F0F0F0F, 0, 0, scnt, rlate);
        check("both_wb_sel", {30'd0, wb_sel}, 32'd1);
        check("both_reg_wr", {31'd0, reg_wr}, 32'd1);
        check("both_rdata", rdata_q, 32'h0F0F0F0F);
        idle_cycle("both_post");

        // Reset during WAIT, then a stray rvalid.
        instr_valid = 1'b1;
        is_load     = 1'b1;
        is_store    = 1'b0;
        rd_in       = 5'd8;
        mem_gnt     = 1'b1;
        mem_rvalid  = 1'b0;
        @(posedge clk);
        #1;
        mem_gnt = 1'b0;
        @(negedge clk);
        check("rstw_stall", {31'd0, stall}, 32'd1);
        #1;
        rst = 1'b1;
        #1;
        check("rstw_stall_rst", {31'd0, stall}, 32'd0);
        check("rstw_rdata_rst", rdata_q, 32'd0);
        @(posedge clk);
        #1;
        rst         = 1'b0;
        instr_valid = 1'b0;
        is_load     = 1'b0;
        mem_rvalid  = 1'b1;
        mem_rdata   = 32'hFFFFFFFF;
        @(negedge clk);
        check("stray_reg_wr", {31'd0, reg_wr}, 32'd0);
        check("stray_stall", {31'd0, stall}, 32'd0);
        check("stray_wb_sel", {30'd0, wb_sel}, 32'd0);
        @(posedge clk);
        #1;
        mem_rvalid = 1'b0;
        @(negedge clk);
        check("stray_rdata", rdata_q, 32'd0);
        check("stray_reg_wr2", {31'd0, reg_wr}, 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
